// File: rtl/hazard_fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_fwd_scoreboard
//
// Hazard and forwarding controller for an RV32I pipeline with FWD_STAGES
// forwarding stages past decode. A shift-register scoreboard tracks in-flight
// destination writes (e[0] = youngest, in EX). Each decode source operand is
// looked up against it to produce a bypass select, and load-use, branch and
// hold conditions are prioritised into stall/flush controls.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   id_valid               decode slot holds a real instruction
//   id_rs1/id_rs2          decode source registers
//   id_rs1_used/_rs2_used  instruction actually reads that source
//   id_rd, id_reg_wr       decode destination and its write enable
//   id_is_load             decode instruction is a load
//   branch_taken           redirect resolved this cycle
//   hold                   external global freeze
//   fwd_sel_a/fwd_sel_b    0 = register file, k+1 = stage k result
//   stall_f, stall_d       hold PC / decode register
//   flush_d, flush_e       clear decode register / bubble into execute
//
// Optional build macro HAZARD_PERF_EN adds lu_stall_cnt and flush_cnt
// (32-bit wrapping event counters, cleared by rst).
// ---------------------------------------------------------------------------
module hazard_fwd_scoreboard #(
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int REG_AW     = 5,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_wr,
    input  logic              id_is_load,
    input  logic              branch_taken,
    input  logic              hold,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       lu_stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    // Scoreboard entries, split into fields; only vld needs a reset.
    logic [FWD_STAGES-1:0] vld_q, vld_d;
    logic [FWD_STAGES-1:0] ld_q,  ld_d;
    logic [REG_AW-1:0]     rd_q [FWD_STAGES];
    logic [REG_AW-1:0]     rd_d [FWD_STAGES];

    logic [SEL_W-1:0] sel_a, sel_b;
    logic             lu_a, lu_b, lu;

    // Returns {hazard, select}. Scanning oldest to youngest lets the youngest
    // matching entry overwrite older ones.
    function automatic logic [SEL_W:0] lookup(input logic [REG_AW-1:0] rs,
                                              input logic              used);
        logic [SEL_W-1:0] sel;
        logic             haz;
        sel = '0;
        haz = 1'b0;
        if (id_valid && used && (rs != '0)) begin
            for (int k = FWD_STAGES - 1; k >= 0; k--) begin
                if (vld_q[k] && (rd_q[k] == rs)) begin
                    sel = SEL_W'(k + 1);
                    haz = ld_q[k] && (k < LOAD_LAT);
                end
            end
        end
        if (haz) sel = '0;
        return {haz, sel};
    endfunction

    always_comb begin
        {lu_a, sel_a} = lookup(id_rs1, id_rs1_used);
        {lu_b, sel_b} = lookup(id_rs2, id_rs2_used);
        lu = lu_a | lu_b;
    end

    // Control priority: hold > branch > load-use. Outputs are forced low while
    // rst is asserted so a reset mid-stall releases everything immediately.
    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        if (!rst) begin
            fwd_sel_a = sel_a;
            fwd_sel_b = sel_b;
            if (hold) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
            end else if (branch_taken) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // Scoreboard advance; a stalled or flushed decode enters EX as a bubble.
    always_comb begin
        vld_d = vld_q;
        ld_d  = ld_q;
        rd_d  = rd_q;
        if (!hold) begin
            for (int k = 1; k < FWD_STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                ld_d[k]  = ld_q[k-1];
                rd_d[k]  = rd_q[k-1];
            end
            vld_d[0] = !(stall_d || flush_d) && id_valid && id_reg_wr && (id_rd != '0);
            ld_d[0]  = id_is_load;
            rd_d[0]  = id_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
        ld_q <= ld_d;
        rd_q <= rd_d;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] lu_stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_stall_cnt_q <= '0;
            flush_cnt_q    <= '0;
        end else begin
            if (!hold && !branch_taken && lu) lu_stall_cnt_q <= lu_stall_cnt_q + 32'd1;
            if (!hold && branch_taken)        flush_cnt_q    <= flush_cnt_q + 32'd1;
        end
    end

    assign lu_stall_cnt = lu_stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
`endif

endmodule
